// File: rtl/ddr2_local_pkg.sv
// Shared types and helpers for the DDR2 local-interface burst reader.
package ddr2_local_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } state_t;

  localparam logic LOCAL_SIZE_ONE = 1'b1;

  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth) r++;
    return r;
  endfunction

endpackage

// File: rtl/ddr2_rdata_fifo.sv
// Show-ahead read-return buffer: registered write, combinational head, synchronous flush.
module ddr2_rdata_fifo
  import ddr2_local_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int CW     = clog2_depth(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [CW-1:0]     count
);

  localparam int AW = CW - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              wr_ok;
  logic              rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/ddr2_local_burst_reader.sv
// Issues single-beat local reads under a FIFO credit limit and streams the returned words.
module ddr2_local_burst_reader
  import ddr2_local_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 64,
  parameter int CNT_W      = 24,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  output logic                err_unexpected,
  input  logic                local_init_done,
  input  logic                local_ready,
  output logic                local_read_req,
  output logic                local_burstbegin,
  output logic [ADDR_W-1:0]   local_address,
  output logic                local_size,
  output logic                local_write_req,
  output logic [DATA_W-1:0]   local_wdata,
  output logic [DATA_W/8-1:0] local_be,
  input  logic [DATA_W-1:0]   local_rdata,
  input  logic                local_rdata_valid,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready
);

  localparam int CW = clog2_depth(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CW-1:0]     os_q, os_d;
  logic [CW-1:0]     fifo_count, fc_d;
  logic [CW:0]       committed_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              accept;
  logic              ret_valid;
  logic              unexpected;
  logic              abort_ok;
  logic              start_ok;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_empty;
  logic              hold;
  logic              raise;

  assign local_size       = LOCAL_SIZE_ONE;
  assign local_write_req  = 1'b0;
  assign local_wdata      = '0;
  assign local_be         = '1;

  // The request is masked whenever calibration is not (or no longer) complete.
  assign local_read_req   = req_q & local_init_done;
  assign local_burstbegin = local_read_req;
  assign local_address    = addr_q;
  assign err_unexpected   = err_q;

  assign busy = (state_q == S_WAIT_INIT) || (state_q == S_ISSUE) ||
                (state_q == S_DRAIN) || (state_q == S_FLUSH);
  assign done = (state_q == S_DONE);

  assign accept     = local_read_req & local_ready;
  assign ret_valid  = local_rdata_valid & (os_q != '0);
  assign unexpected = local_rdata_valid & (os_q == '0);
  assign start_ok   = start & (state_q == S_IDLE);
  assign abort_ok   = abort & ((state_q == S_WAIT_INIT) || (state_q == S_ISSUE) ||
                               (state_q == S_DRAIN));

  assign st_valid = ~fifo_empty & (state_q != S_FLUSH);
  assign fifo_rd  = st_valid & st_ready;
  assign fifo_wr  = ret_valid & ~abort_ok & (state_q != S_FLUSH);

  // Slots committed next cycle = in flight + buffered; returns move a word between the two.
  assign os_d        = os_q + CW'(accept) - CW'(ret_valid);
  assign fc_d        = abort_ok ? '0 : (fifo_count + CW'(fifo_wr) - CW'(fifo_rd));
  assign committed_d = (CW + 1)'(os_d) + (CW + 1)'(fc_d);
  assign issued_d    = issued_q + CNT_W'(accept);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (word_count == '0) ? S_DONE : S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (abort_ok)             state_d = S_FLUSH;
        else if (local_init_done) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort_ok)                          state_d = S_FLUSH;
        else if (accept && issued_d == cnt_q)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_ok)                          state_d = S_FLUSH;
        else if (os_d == '0 && fc_d == '0)     state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FLUSH: begin
        if (os_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold   = req_q & ~accept & ~abort_ok;
    raise  = (state_d == S_ISSUE) && (issued_d < cnt_q) &&
             (committed_d < (CW + 1)'(FIFO_DEPTH));
    req_d  = hold | raise;
    addr_d = addr_q;
    if (!hold && raise) addr_d = base_q + ADDR_W'(issued_d);
    err_d = err_q;
    if (start_ok)   err_d = 1'b0;
    if (unexpected) err_d = 1'b1;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      os_q     <= '0;
      issued_q <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      os_q     <= os_d;
      issued_q <= start_ok ? '0 : issued_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Transfer descriptor, captured when a start is accepted
  always_ff @(posedge clk) begin
    if (start_ok) begin
      base_q <= base_addr;
      cnt_q  <= word_count;
    end
  end

  ddr2_rdata_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CW     (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (abort_ok),
    .wr_en   (fifo_wr),
    .wr_data (local_rdata),
    .rd_en   (fifo_rd),
    .rd_data (st_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_ddr2_local_burst_reader.sv
// Directed bench with a controller model returning reads 6 cycles after accept.
module tb_ddr2_local_burst_reader;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 24;
  localparam int DEPTH   = 4;
  localparam int RET_LAT = 6;

  typedef struct {
    int              due;
    logic [DATA_W-1:0] d;
  } ret_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                abort;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    word_count;
  logic                busy;
  logic                done;
  logic                err_unexpected;
  logic                local_init_done;
  logic                local_ready;
  logic                local_read_req;
  logic                local_burstbegin;
  logic [ADDR_W-1:0]   local_address;
  logic                local_size;
  logic                local_write_req;
  logic [DATA_W-1:0]   local_wdata;
  logic [DATA_W/8-1:0] local_be;
  logic [DATA_W-1:0]   local_rdata;
  logic                local_rdata_valid;
  logic [DATA_W-1:0]   st_data;
  logic                st_valid;
  logic                st_ready;

  int n_chk = 0;
  int n_pass = 0;
  int cycle = 0;
  int n_acc = 0;
  int quota = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: ready until quota accepts
  int st_mode = 1;      // 0: st_ready low, 1: high, 2: random
  int last_handoff = -1;
  int last_ret = -1;
  logic inject = 1'b0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  ret_t              ret_q[$];

  ddr2_local_burst_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .err_unexpected    (err_unexpected),
    .local_init_done   (local_init_done),
    .local_ready       (local_ready),
    .local_read_req    (local_read_req),
    .local_burstbegin  (local_burstbegin),
    .local_address     (local_address),
    .local_size        (local_size),
    .local_write_req   (local_write_req),
    .local_wdata       (local_wdata),
    .local_be          (local_be),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] fdata(input logic [ADDR_W-1:0] a);
    return {8'hD0, 1'b0, a, 9'h0, a};
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] b, input int cnt);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = b + ADDR_W'(i);
      exp_addr.push_back(a);
      exp_data.push_back(fdata(a));
    end
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    word_count = CNT_W'(cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    logic got;
    got = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      #3;
      if (done) begin
        got = 1'b1;
        done_cyc = cycle;
      end
    end
    check("done_seen", DATA_W'(got), 1);
  endtask

  initial begin
    int dc, acc0, fall_cyc;
    logic req_seen, sv_seen, dn_seen, fell;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    word_count = '0;
    local_init_done = 1'b1;
    local_ready = 1'b1;
    local_rdata = '0;
    local_rdata_valid = 1'b0;
    st_ready = 1'b1;

    fork
      begin : monitor
        ret_t r;
        logic pend_prev, hold_prev;
        logic [ADDR_W-1:0] pend_addr;
        logic [DATA_W-1:0] hold_data;
        pend_prev = 1'b0;
        hold_prev = 1'b0;
        pend_addr = '0;
        hold_data = '0;
        forever begin
          @(negedge clk);
          cycle++;
          #1;
          local_rdata_valid = 1'b0;
          local_rdata = '0;
          if (ret_q.size() > 0 && ret_q[0].due <= cycle) begin
            r = ret_q.pop_front();
            local_rdata_valid = 1'b1;
            local_rdata = r.d;
            last_ret = cycle;
          end else if (inject) begin
            local_rdata_valid = 1'b1;
            local_rdata = 64'hDEAD;
          end
          case (ready_mode)
            0:       local_ready = 1'b1;
            1:       local_ready = 1'($urandom_range(0, 1));
            default: local_ready = (n_acc < quota);
          endcase
          case (st_mode)
            0:       st_ready = 1'b0;
            1:       st_ready = 1'b1;
            default: st_ready = 1'($urandom_range(0, 1));
          endcase
          #1;
          if (!reset) begin
            if (pend_prev) begin
              check("req_held", DATA_W'(local_read_req), 1);
              check("addr_held", DATA_W'(local_address), DATA_W'(pend_addr));
            end
            if (hold_prev && st_valid)
              check("st_data_held", st_data, hold_data);
            if (local_read_req && local_ready) begin
              n_acc++;
              if (exp_addr.size() == 0) check("addr_extra", 1, 0);
              else check("req_addr", DATA_W'(local_address), DATA_W'(exp_addr.pop_front()));
              r.due = cycle + RET_LAT;
              r.d = fdata(local_address);
              ret_q.push_back(r);
            end
            if (st_valid && st_ready) begin
              last_handoff = cycle;
              if (exp_data.size() == 0) check("st_extra", 1, 0);
              else check("st_data", st_data, exp_data.pop_front());
            end
            pend_prev = local_read_req & ~local_ready & ~abort;
            pend_addr = local_address;
            hold_prev = st_valid & ~st_ready & ~abort;
            hold_data = st_data;
          end else begin
            pend_prev = 1'b0;
            hold_prev = 1'b0;
          end
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check("rst_busy", DATA_W'(busy), 0);
    check("rst_done", DATA_W'(done), 0);
    check("rst_err", DATA_W'(err_unexpected), 0);
    check("rst_req", DATA_W'(local_read_req), 0);
    check("rst_addr", DATA_W'(local_address), 0);
    check("rst_st_valid", DATA_W'(st_valid), 0);
    check("const_size", DATA_W'(local_size), 1);
    check("const_wreq", DATA_W'(local_write_req), 0);
    check("const_be", DATA_W'(local_be), 8'hFF);
    check("const_wdata", local_wdata, 0);

    // Address wrap, in-order stream, done one cycle after last handoff
    start_xfer(23'h7FFFFE, 4);
    wait_done(100, dc);
    check("done_after_handoff", DATA_W'(dc), DATA_W'(last_handoff + 1));
    check("t1_data_left", DATA_W'(exp_data.size()), 0);
    @(negedge clk);
    #3;
    check("done_one_cycle", DATA_W'(done), 0);
    check("t1_busy_low", DATA_W'(busy), 0);

    // Credit limit with a stalled consumer
    acc0 = n_acc;
    st_mode = 0;
    start_xfer(23'h000100, 10);
    repeat (40) @(negedge clk);
    #3;
    check("credit_accepts", DATA_W'(n_acc - acc0), DEPTH);
    check("credit_req_low", DATA_W'(local_read_req), 0);
    check("credit_st_valid", DATA_W'(st_valid), 1);
    @(negedge clk);
    st_mode = 1;
    wait_done(300, dc);
    check("t2_accepts", DATA_W'(n_acc - acc0), 10);
    check("t2_data_left", DATA_W'(exp_data.size()), 0);

    // Random local_ready and random st_ready, wrapping address
    ready_mode = 1;
    st_mode = 2;
    acc0 = n_acc;
    start_xfer(23'h7FFFF8, 12);
    wait_done(600, dc);
    check("t3_accepts", DATA_W'(n_acc - acc0), 12);
    check("t3_addr_left", DATA_W'(exp_addr.size()), 0);
    check("t3_data_left", DATA_W'(exp_data.size()), 0);
    ready_mode = 0;
    st_mode = 1;

    // Calibration not complete
    local_init_done = 1'b0;
    start_xfer(23'h000200, 3);
    req_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (local_read_req) req_seen = 1'b1;
    end
    check("no_req_before_init", DATA_W'(req_seen), 0);
    check("busy_waiting_init", DATA_W'(busy), 1);
    @(negedge clk);
    local_init_done = 1'b1;
    wait_done(100, dc);
    check("t4_data_left", DATA_W'(exp_data.size()), 0);

    // Abort with three reads outstanding
    quota = n_acc + 3;
    ready_mode = 2;
    start_xfer(23'h000400, 8);
    for (int i = 0; i < 30 && n_acc < quota; i++) begin
      @(negedge clk);
      #3;
    end
    check("abort_accepts", DATA_W'(n_acc), DATA_W'(quota));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sv_seen = 1'b0;
    dn_seen = 1'b0;
    fell = 1'b0;
    fall_cyc = -1;
    for (int i = 0; i < 40 && !fell; i++) begin
      #3;
      if (st_valid) sv_seen = 1'b1;
      if (done) dn_seen = 1'b1;
      if (!busy) begin
        fell = 1'b1;
        fall_cyc = cycle;
      end else begin
        @(negedge clk);
      end
    end
    check("flush_st_valid", DATA_W'(sv_seen), 0);
    check("flush_no_done", DATA_W'(dn_seen), 0);
    check("flush_busy_fall", DATA_W'(fall_cyc), DATA_W'(last_ret + 1));
    check("flush_ret_left", DATA_W'(ret_q.size()), 0);
    check("flush_err", DATA_W'(err_unexpected), 0);
    exp_addr.delete();
    exp_data.delete();
    ready_mode = 0;
    start_xfer(23'h000010, 2);
    wait_done(100, dc);
    check("post_abort_data_left", DATA_W'(exp_data.size()), 0);

    // Abort in idle is ignored
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #3;
    check("idle_abort_busy", DATA_W'(busy), 0);

    // Unexpected return, then zero-length start clears the flag
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #3;
    check("err_set", DATA_W'(err_unexpected), 1);
    @(negedge clk);
    start = 1'b1;
    base_addr = 23'h000055;
    word_count = '0;
    @(negedge clk);
    start = 1'b0;
    #3;
    check("zero_cnt_done", DATA_W'(done), 1);
    check("err_cleared", DATA_W'(err_unexpected), 0);
    check("zero_cnt_busy", DATA_W'(busy), 0);
    check("zero_cnt_req", DATA_W'(local_read_req), 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr2_local_burst_reader.md
Name: ddr2_local_burst_reader

Overview:
Initiator for the DDR2 controller's local (half-rate) read interface.
- Given a base address and word count, it issues single-beat local read requests (local_size=1) and tracks outstanding reads against free FIFO space.
- Returned local_rdata is buffered and presented as a valid/ready stream to downstream consumers, such as the LCD pixel pipeline.
- Runs in the phy_clk domain. The write side of the local interface is tied inactive.

Parameters:
ADDR_W, 23, local_address width (local words)
DATA_W, 64, local_rdata / stream data width
CNT_W, 24, word_count width
FIFO_DEPTH, 32, read-return buffer depth in words (power of 2, >=4)

Ports:
clk  in  1  phy_clk from controller
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; launches a transfer when idle
abort  in  1  one-cycle pulse; cancels the transfer in progress
base_addr  in  ADDR_W  first local word address
word_count  in  CNT_W  number of local words to read
busy  out  1  high from accepted start until done/abort completes
done  out  1  one-cycle pulse at transfer completion
err_unexpected  out  1  sticky; rdata_valid seen with zero outstanding; cleared by reset or start
local_init_done  in  1  controller calibration complete
local_ready  in  1  controller accepts a request this cycle
local_read_req  out  1  read request
local_burstbegin  out  1  equals local_read_req
local_address  out  ADDR_W  request address
local_size  out  1  constant 1
local_write_req  out  1  constant 0
local_wdata  out  DATA_W  constant 0
local_be  out  DATA_W/8  all ones
local_rdata  in  DATA_W  returned data
local_rdata_valid  in  1  returned data valid
st_data  out  DATA_W  stream data
st_valid  out  1  stream valid
st_ready  in  1  stream ready

Behaviour:
Reset values:
- busy, done, err_unexpected, local_read_req, st_valid = 0; local_address = 0.
- FIFO empty; outstanding = 0; state = IDLE.

Request handshake:
- A request is accepted on a clk edge where local_read_req & local_ready.
- Once asserted, local_read_req and local_address hold stable until accepted.
- local_read_req is never asserted while local_init_done = 0.

Credit rule:
- A new request may be raised only if outstanding + fifo_count + 1 <= FIFO_DEPTH.
- The FIFO therefore never overflows; local_rdata_valid has no backpressure.

Counters:
- outstanding increments on accept, decrements on rdata_valid. Both in the same cycle leave it unchanged.
- Address = base_addr + issued_count, modulo 2^ADDR_W (wraps silently).

States:
- IDLE
  - start → clear err_unexpected, latch base/count, busy=1.
  - count==0 → DONE.
  - Otherwise WAIT_INIT.
- WAIT_INIT: local_init_done=1 → ISSUE.
- ISSUE
  - Raise requests per the credit rule; back-to-back accepts allowed, one per cycle.
  - Last accept → DRAIN.
- DRAIN: outstanding==0 and FIFO empty and last word handed off → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- FLUSH (entered on abort from WAIT_INIT/ISSUE/DRAIN)
  - Request is dropped only if not being accepted that same cycle. If accepted, it counts as outstanding.
  - FIFO is cleared; st_valid=0.
  - Returning rdata is discarded until outstanding==0 → IDLE.
  - No done pulse is generated.

Latency and stream:
- rdata_valid to st_valid: 1 cycle when the FIFO is empty (registered write, show-ahead read).
- st_data is held stable while st_valid & !st_ready.

Simultaneous events and edge cases:
- start while busy: ignored.
- abort in IDLE or DONE: ignored.
- start and abort together in IDLE: start wins.
- rdata_valid with outstanding==0: err_unexpected=1, data dropped, outstanding stays 0.
- Reset mid-transfer returns to IDLE immediately. The controller must be reset alongside; returning data afterwards flags err_unexpected.

Decomposition:
- Package ddr2_local_pkg holds:
  - the state enum;
  - the LOCAL_SIZE_ONE constant;
  - a function for clog2 of FIFO_DEPTH.
- One sub-module, ddr2_rdata_fifo: synchronous show-ahead FIFO with count output and synchronous flush.

Test Plan:
- start with base=0x7FFFFE, count=4, ready always 1, rdata returning 6 cycles after each accept → addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001; 4 words streamed in order; done one cycle after the last handoff.
- FIFO_DEPTH=4, count=10, st_ready=0 for 40 cycles → exactly 4 requests accepted and read_req held low. Release st_ready → all 10 words delivered in order.
- local_ready toggles 1/0 randomly → read_req and address stay stable while unaccepted; no duplicate or skipped addresses.
- local_init_done=0 for 50 cycles after start → no read_req until init_done rises; then normal completion.
- abort after 3 accepts with 3 outstanding → FLUSH discards 3 returns, st_valid stays 0, no done pulse, busy falls after the last return.
- rdata_valid pulse in IDLE → err_unexpected=1; a following start with count=0 clears it and pulses done one cycle later.
